id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mini_rv_pkg.sv | 30 +++
 rtl/rv_regfile.sv | 28 ++
 rtl/id_ex_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/mini_rv_pkg.sv
// Shared encodings for the mini RV32I integer decode/execute slice.
// Opcode, funct3/funct7 names, stage states and the ALU control bundle.
package mini_rv_pkg;

    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] FAULT   = 1'b1;

    typedef struct packed {
        logic [2:0] sel;
        logic       addb;
        logic       rightb;
        logic       logicb;
    } ctl_t;

endpackage

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two async read ports, one sync write port.
// x0 always reads zero and ignores writes; sync reset clears everything.
module rv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/id_ex_stage.sv
// Decode + operand fetch for RV32I OP/OP-IMM, presenting registered ALU inputs.
// The ALU result s comes back combinationally and is written back / bypassed.
module id_ex_stage
    import mini_rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  sel,
    output logic        addb,
    output logic        rightb,
    output logic        logicb,
    output logic        out_valid,
    input  logic [31:0] s,
    output logic        fault,
    output logic [31:0] fault_instr,
    output logic [31:0] retired
);

    logic [0:0]  state;
    logic [4:0]  rd_ex;
    logic [31:0] rs1_rf, rs2_rf;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] a_nx, b_nx;
    logic        illegal, accept;
    ctl_t        ctl_nx;

    wire [6:0] opcode = instr[6:0];
    wire [4:0] rd     = instr[11:7];
    wire [2:0] f3     = instr[14:12];
    wire [4:0] rs1    = instr[19:15];
    wire [4:0] rs2    = instr[24:20];
    wire [6:0] f7     = instr[31:25];

    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;

    rv_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (out_valid && rd_ex != 5'd0),
        .waddr  (rd_ex),
        .wdata  (s),
        .raddr1 (rs1),
        .rdata1 (rs1_rf),
        .raddr2 (rs2),
        .rdata2 (rs2_rf)
    );

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP:      illegal = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            OP_IMM: begin
                if (f3 == F3_SLL)     illegal = (f7 != F7_BASE);
                else if (f3 == F3_SR) illegal = !(f7 == F7_BASE || f7 == F7_ALT);
            end
            default: illegal = 1'b1;
        endcase
    end

    // The writeback of the op on the outputs lands at the same edge, so its result is forwarded.
    assign rs1_val = (out_valid && rd_ex != 5'd0 && rd_ex == rs1) ? s : rs1_rf;
    assign rs2_val = (out_valid && rd_ex != 5'd0 && rd_ex == rs2) ? s : rs2_rf;

    always_comb begin
        a_nx = rs1_val;
        if (opcode == OP)                     b_nx = rs2_val;
        else if (f3 == F3_SLL || f3 == F3_SR) b_nx = {27'd0, instr[24:20]};
        else                                  b_nx = {{20{instr[31]}}, instr[31:20]};
        ctl_nx.sel    = f3;
        ctl_nx.addb   = (opcode == OP) && (f3 == F3_ADD) && (f7 == F7_ALT);
        ctl_nx.rightb = (f3 == F3_SR) && (f7 == F7_ALT);
        ctl_nx.logicb = (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            out_valid   <= 1'b0;
            a           <= '0;
            b           <= '0;
            sel         <= '0;
            addb        <= 1'b0;
            rightb      <= 1'b0;
            logicb      <= 1'b0;
            rd_ex       <= '0;
            fault       <= 1'b0;
            fault_instr <= '0;
            retired     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (out_valid) retired <= retired + 32'd1;
            if (accept) begin
                if (illegal) begin
                    state       <= FAULT;
                    fault       <= 1'b1;
                    fault_instr <= instr;
                end else begin
                    out_valid <= 1'b1;
                    a         <= a_nx;
                    b         <= b_nx;
                    sel       <= ctl_nx.sel;
                    addb      <= ctl_nx.addb;
                    rightb    <= ctl_nx.rightb;
                    logicb    <= ctl_nx.logicb;
                    rd_ex     <= rd;
                end
            end
        end
    end

endmodule
